// File: rtl/gnr_ctrl_pkg.sv
// Shared definitions for the GNR attractor controller.
//   ctrl_state_e : controller FSM states
//   CNT_W_DEF    : default width of the step / period counters
package gnr_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PERIOD,
    DONE
  } ctrl_state_e;

endpackage

// File: rtl/gnr_state_cmp.sv
// Combinational equality comparator for the tortoise/hare state vectors.
// Ports:
//   s0_vec  in  N_NODES  tortoise copy of the network state
//   s1_vec  in  N_NODES  hare copy of the network state
//   qualify in  1        comparison is meaningful this cycle
//   eq      out 1        qualify && (s0_vec == s1_vec)
module gnr_state_cmp #(
  parameter int N_NODES = 16
) (
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  input  logic               qualify,
  output logic               eq
);

  assign eq = qualify && (s0_vec == s1_vec);

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Control end of the Boolean-network node interface for one GNR network.
// Loads an initial state into every node, runs Floyd cycle detection
// (tortoise s0 at half rate inside the nodes, hare s1 every cycle) and
// optionally measures the attractor period, then returns the result over
// a valid/ready channel.
//
// Optional feature macro: GNR_PERIOD_MEASURE_EN
//   defined   : PERIOD phase measures the attractor period
//   undefined : a meet goes straight to DONE, res_period is tied to 0
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      initial-state request handshake
//   req_state                initial network state
//   reset_nos, init_state    node load strobe and per-node initial bits
//   start_s0, start_s1       tortoise / hare step strobes
//   s0_vec, s1_vec           concatenated node outputs
//   res_valid/res_ready      result handshake
//   res_state                attractor state
//   res_steps                hare steps until meet (or abort)
//   res_period               attractor period (0 when not measured)
//   res_timeout              MAX_STEPS reached without meet/closure
module gnr_attractor_ctrl
  import gnr_ctrl_pkg::*;
#(
  parameter int N_NODES   = 16,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_STEPS = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [N_NODES-1:0] req_state,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_NODES-1:0] res_state,
  output logic [CNT_W-1:0]   res_steps,
  output logic [CNT_W-1:0]   res_period,
  output logic               res_timeout
);

  ctrl_state_e        state_q, state_d;
  logic [CNT_W-1:0]   k_q;
  logic [N_NODES-1:0] init_q;
  logic [N_NODES-1:0] res_state_q;
  logic [CNT_W-1:0]   res_steps_q;
  logic               res_timeout_q;
  logic               qualify;
  logic               eq;
  logic               k_at_max;

  assign k_at_max = (k_q == CNT_W'(MAX_STEPS));

`ifdef GNR_PERIOD_MEASURE_EN
  logic [CNT_W-1:0] p_q;
  logic [CNT_W-1:0] res_period_q;
  logic             p_at_max;

  assign p_at_max = (p_q == CNT_W'(MAX_STEPS));

  // At k=0 and k=1 both copies sit on the same step index, so a match there
  // is trivial; in PERIOD p=0 is the meet point itself.
  assign qualify = ((state_q == RUN)    && (k_q >= CNT_W'(2))) ||
                   ((state_q == PERIOD) && (p_q >= CNT_W'(1)));
  assign res_period = res_period_q;
`else
  assign qualify    = (state_q == RUN) && (k_q >= CNT_W'(2));
  assign res_period = '0;
`endif

  gnr_state_cmp #(
    .N_NODES(N_NODES)
  ) u_cmp (
    .s0_vec (s0_vec),
    .s1_vec (s1_vec),
    .qualify(qualify),
    .eq     (eq)
  );

  // rst gating keeps req_ready low while reset is held.
  assign req_ready   = (state_q == IDLE) && !rst;
  assign reset_nos   = (state_q == LOAD);
  assign res_valid   = (state_q == DONE);
  assign init_state  = init_q;
  assign res_state   = res_state_q;
  assign res_steps   = res_steps_q;
  assign res_timeout = res_timeout_q;

  always_comb begin
    state_d  = state_q;
    start_s0 = 1'b0;
    start_s1 = 1'b0;
    case (state_q)
      IDLE: if (req_valid) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN: begin
        // Steps are withheld on the meet/abort cycle so the nodes keep the
        // captured state.
        if (eq) begin
`ifdef GNR_PERIOD_MEASURE_EN
          state_d = PERIOD;
`else
          state_d = DONE;
`endif
        end else if (k_at_max) begin
          state_d = DONE;
        end else begin
          start_s0 = 1'b1;
          start_s1 = 1'b1;
        end
      end
`ifdef GNR_PERIOD_MEASURE_EN
      PERIOD: begin
        if (eq || p_at_max) state_d  = DONE;
        else                start_s1 = 1'b1;
      end
`endif
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      k_q           <= '0;
      init_q        <= '0;
      res_state_q   <= '0;
      res_steps_q   <= '0;
      res_timeout_q <= 1'b0;
`ifdef GNR_PERIOD_MEASURE_EN
      p_q           <= '0;
      res_period_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            init_q        <= req_state;
            res_state_q   <= '0;
            res_steps_q   <= '0;
            res_timeout_q <= 1'b0;
`ifdef GNR_PERIOD_MEASURE_EN
            res_period_q  <= '0;
`endif
          end
        end
        LOAD: k_q <= '0;
        RUN: begin
          if (eq) begin
            res_state_q <= s0_vec;
            res_steps_q <= k_q;
`ifdef GNR_PERIOD_MEASURE_EN
            p_q         <= '0;
`endif
          end else if (k_at_max) begin
            res_state_q   <= s1_vec;
            res_steps_q   <= k_q;
            res_timeout_q <= 1'b1;
          end else begin
            // Only increments below MAX_STEPS, so the counter never wraps.
            k_q <= k_q + CNT_W'(1);
          end
        end
`ifdef GNR_PERIOD_MEASURE_EN
        PERIOD: begin
          if (eq) begin
            res_period_q <= p_q;
          end else if (p_at_max) begin
            res_timeout_q <= 1'b1;
            res_period_q  <= '0;
          end else begin
            p_q <= p_q + CNT_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench for gnr_attractor_ctrl with a behavioural node array:
// each node holds s0/s1 copies, s0 advances on every second start_s0
// (first assertion after load steps), s1 on every start_s1.
module tb_gnr_attractor_ctrl;

  localparam int N = 16;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [N-1:0] req_state = '0;
  logic         reset_nos;
  logic [N-1:0] init_state;
  logic         start_s0;
  logic         start_s1;
  logic [N-1:0] s0_m = '0;
  logic [N-1:0] s1_m = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [N-1:0] res_state;
  logic [W-1:0] res_steps;
  logic [W-1:0] res_period;
  logic         res_timeout;

  logic         pass_m = 1'b1;
  int unsigned  s1_cnt = 0;
  int           mode = 0;
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  gnr_attractor_ctrl #(
    .N_NODES  (N),
    .CNT_W    (W),
    .MAX_STEPS(20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_state  (req_state),
    .reset_nos  (reset_nos),
    .init_state (init_state),
    .start_s0   (start_s0),
    .start_s1   (start_s1),
    .s0_vec     (s0_m),
    .s1_vec     (s1_m),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_state  (res_state),
    .res_steps  (res_steps),
    .res_period (res_period),
    .res_timeout(res_timeout)
  );

  // Network update functions: 0 fixed point, 1 three-node ring,
  // 2 transient 0..4 into cycle 5..8, 3 free-running counter.
  function automatic logic [N-1:0] f_next(input int md, input logic [N-1:0] s);
    case (md)
      1:       f_next = {s[N-1:3], s[1:0], s[2]};
      2:       f_next = (s >= 16'd8) ? 16'd5 : s + 16'd1;
      3:       f_next = s + 16'd1;
      default: f_next = s;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset_nos) begin
      s0_m   <= init_state;
      s1_m   <= init_state;
      pass_m <= 1'b1;
      s1_cnt <= 0;
    end else begin
      if (start_s0) begin
        if (pass_m) s0_m <= f_next(mode, s0_m);
        pass_m <= ~pass_m;
      end
      if (start_s1) begin
        s1_m   <= f_next(mode, s1_m);
        s1_cnt <= s1_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request and wait for res_valid; cyc counts cycles from accept.
  task automatic run_req(input logic [N-1:0] st, output int cyc);
    int n = 0;
    req_state = st;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    req_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    tests++; if ({res_valid, reset_nos, start_s0, start_s1, res_timeout} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl got=%b exp=00000", {res_valid, reset_nos, start_s0, start_s1, res_timeout}); end
    tests++; if ({init_state, res_state, res_steps, res_period} !== 64'h0) begin
      fails++; $display("FAIL reset_data got=%h exp=0", {init_state, res_state, res_steps, res_period}); end
    rst = 1'b0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_idle_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_fixed_point();
    int cyc;
    mode = 0;
    run_req(16'h00A5, cyc);
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL fixed_valid got=%b exp=1", res_valid); end
`ifdef GNR_PERIOD_MEASURE_EN
    tests++; if (cyc != 6) begin fails++; $display("FAIL fixed_latency got=%0d exp=6", cyc); end
    tests++; if (res_period !== 16'd1) begin fails++; $display("FAIL fixed_period got=%0d exp=1", res_period); end
    tests++; if (s1_cnt != 3) begin fails++; $display("FAIL fixed_s1_steps got=%0d exp=3", s1_cnt); end
`else
    tests++; if (cyc != 4) begin fails++; $display("FAIL fixed_latency got=%0d exp=4", cyc); end
    tests++; if (res_period !== 16'd0) begin fails++; $display("FAIL fixed_period got=%0d exp=0", res_period); end
    tests++; if (s1_cnt != 2) begin fails++; $display("FAIL fixed_s1_steps got=%0d exp=2", s1_cnt); end
`endif
    tests++; if (res_steps !== 16'd2) begin fails++; $display("FAIL fixed_steps got=%0d exp=2", res_steps); end
    tests++; if (res_state !== 16'h00A5) begin fails++; $display("FAIL fixed_state got=%h exp=00a5", res_state); end
    tests++; if (res_timeout !== 1'b0) begin fails++; $display("FAIL fixed_timeout got=%b exp=0", res_timeout); end
    release_result();
    tests++; if ({res_valid, req_ready} !== 2'b01) begin fails++; $display("FAIL fixed_release got=%b exp=01", {res_valid, req_ready}); end
  endtask

  task automatic test_ring();
    int cyc;
    mode = 1;
    run_req(16'h0001, cyc);
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL ring_valid got=%b exp=1", res_valid); end
    tests++; if (!(res_state == 16'h1 || res_state == 16'h2 || res_state == 16'h4)) begin
      fails++; $display("FAIL ring_state_set got=%h exp=one_of_1_2_4", res_state); end
    tests++; if (res_state !== 16'h0001) begin fails++; $display("FAIL ring_state got=%h exp=0001", res_state); end
    tests++; if (res_steps !== 16'd6) begin fails++; $display("FAIL ring_steps got=%0d exp=6", res_steps); end
`ifdef GNR_PERIOD_MEASURE_EN
    tests++; if (res_period !== 16'd3) begin fails++; $display("FAIL ring_period got=%0d exp=3", res_period); end
`else
    tests++; if (res_period !== 16'd0) begin fails++; $display("FAIL ring_period got=%0d exp=0", res_period); end
`endif
    tests++; if (res_timeout !== 1'b0) begin fails++; $display("FAIL ring_timeout got=%b exp=0", res_timeout); end
    release_result();
  endtask

  task automatic test_transient();
    int cyc;
    logic [N-1:0] g;
    mode = 2;
    run_req(16'h0000, cyc);
    g = res_state;
    for (int unsigned i = 0; i < 4; i++) g = f_next(2, g);
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL trans_valid got=%b exp=1", res_valid); end
    tests++; if (res_steps !== 16'd9) begin fails++; $display("FAIL trans_steps got=%0d exp=9", res_steps); end
    tests++; if (res_state !== 16'h0005) begin fails++; $display("FAIL trans_state got=%h exp=0005", res_state); end
    tests++; if (g !== res_state) begin fails++; $display("FAIL trans_golden4 got=%h exp=%h", g, res_state); end
`ifdef GNR_PERIOD_MEASURE_EN
    tests++; if (res_period !== 16'd4) begin fails++; $display("FAIL trans_period got=%0d exp=4", res_period); end
`else
    tests++; if (res_period !== 16'd0) begin fails++; $display("FAIL trans_period got=%0d exp=0", res_period); end
`endif
    tests++; if (res_timeout !== 1'b0) begin fails++; $display("FAIL trans_timeout got=%b exp=0", res_timeout); end
    release_result();
  endtask

  task automatic test_timeout();
    int cyc;
    mode = 3;
    run_req(16'h0000, cyc);
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL tmo_valid got=%b exp=1", res_valid); end
    tests++; if (res_timeout !== 1'b1) begin fails++; $display("FAIL tmo_flag got=%b exp=1", res_timeout); end
    tests++; if (res_steps !== 16'd20) begin fails++; $display("FAIL tmo_steps got=%0d exp=20", res_steps); end
    tests++; if (res_state !== 16'h0014) begin fails++; $display("FAIL tmo_state got=%h exp=0014", res_state); end
    tests++; if (s1_cnt != 20) begin fails++; $display("FAIL tmo_start_count got=%0d exp=20", s1_cnt); end
    tests++; if (s1_m !== 16'h0014) begin fails++; $display("FAIL tmo_node_s1 got=%h exp=0014", s1_m); end
    tests++; if (res_period !== 16'd0) begin fails++; $display("FAIL tmo_period got=%0d exp=0", res_period); end
    release_result();
  endtask

  task automatic test_mid_reset();
    int n = 0;
    int cyc;
    mode = 1;
    req_state = 16'h0001;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
`ifdef GNR_PERIOD_MEASURE_EN
    while (!(start_s1 && !start_s0) && n < 100) begin tick(); n++; end
`else
    while (!start_s0 && n < 100) begin tick(); n++; end
    tick();
`endif
    tests++; if (n >= 100) begin fails++; $display("FAIL midrst_reach got=%0d exp=<100", n); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got=%b exp=1", req_ready); end
    tests++; if ({res_valid, reset_nos, start_s0, start_s1, res_timeout} !== 5'b0) begin
      fails++; $display("FAIL midrst_ctrl got=%b exp=00000", {res_valid, reset_nos, start_s0, start_s1, res_timeout}); end
    tests++; if ({init_state, res_state, res_steps, res_period} !== 64'h0) begin
      fails++; $display("FAIL midrst_data got=%h exp=0", {init_state, res_state, res_steps, res_period}); end
    mode = 0;
    run_req(16'h00A5, cyc);
    tests++; if ({res_valid, res_state, res_steps} !== {1'b1, 16'h00A5, 16'd2}) begin
      fails++; $display("FAIL midrst_rerun got=%b/%h/%0d exp=1/00a5/2", res_valid, res_state, res_steps); end
    release_result();
  endtask

  task automatic test_hold_done();
    int cyc;
    logic [W-1:0] exp_p;
`ifdef GNR_PERIOD_MEASURE_EN
    exp_p = 16'd1;
`else
    exp_p = 16'd0;
`endif
    mode = 0;
    run_req(16'h003C, cyc);
    req_state = 16'hFFFF;
    req_valid = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      tests++; if ({res_valid, req_ready, reset_nos} !== 3'b100) begin
        fails++; $display("FAIL hold_ctrl[%0d] got=%b exp=100", i, {res_valid, req_ready, reset_nos}); end
      tests++; if ({res_state, res_steps, res_period} !== {16'h003C, 16'd2, exp_p}) begin
        fails++; $display("FAIL hold_data[%0d] got=%h/%0d/%0d exp=003c/2/%0d", i, res_state, res_steps, res_period, exp_p); end
      tests++; if (init_state !== 16'h003C) begin fails++; $display("FAIL hold_init[%0d] got=%h exp=003c", i, init_state); end
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    req_valid = 1'b0;
    tests++; if ({res_valid, req_ready} !== 2'b01) begin fails++; $display("FAIL hold_release got=%b exp=01", {res_valid, req_ready}); end
    tick();
    tests++; if ({req_ready, reset_nos} !== 2'b10) begin fails++; $display("FAIL hold_idle got=%b exp=10", {req_ready, reset_nos}); end
  endtask

  initial begin
    test_reset();
    test_fixed_point();
    test_ring();
    test_transient();
    test_timeout();
    test_mid_reset();
    test_hold_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
